// File: rtl/arinc_pkg.sv
// Shared types, constants and weight helper for the float-to-ARINC angle encoder.
// Fixed-point degrees carry FRAC_W fraction bits; one code LSB is 360/2^CODE_W deg.
package arinc_pkg;

    localparam int CODE_W = 12;
    localparam int FRAC_W = 10;
    localparam int FIX_W  = 19;
    localparam int CNT_W  = 4;

    localparam logic [FIX_W-1:0] FULL_SCALE = FIX_W'(360 << FRAC_W);
    localparam logic [FIX_W-1:0] W0         = FULL_SCALE >> CODE_W;
    localparam logic [FIX_W-1:0] HALF_LSB   = W0 >> 1;

    // Right-shift that maps {1,man} to degrees*2^FRAC_W: bias 127 plus 23 mantissa bits.
    localparam int EXP_BIAS_SHIFT = 127 + 23 - FRAC_W;

    function automatic logic [FIX_W-1:0] arinc_weight(input logic [CNT_W-1:0] k);
        return W0 << k;
    endfunction

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ROUND,
        CONVERT,
        DONE
    } enc_state_t;

endpackage

// File: rtl/fp32_to_fixdeg.sv
// Combinational unpack of an IEEE-754 single angle into unsigned fixed-point degrees.
// Flags NaN/Inf, negative non-zero values and anything at or beyond 360 degrees.
module fp32_to_fixdeg
    import arinc_pkg::*;
(
    input  logic [31:0]      angle,
    output logic [FIX_W-1:0] fixed,
    output logic             err
);

    // At or below this exponent the shift pushes every mantissa bit out.
    localparam int EXP_ZERO_MAX = EXP_BIAS_SHIFT - 24;
    // 2^9 = 512 deg already exceeds a full turn.
    localparam int EXP_ERR_MIN  = 136;

    fp32_t       f;
    logic [23:0] sig;
    logic [7:0]  sh;
    logic [23:0] shifted;

    assign f = angle;

    always_comb begin
        sig     = {1'b1, f.man};
        sh      = 8'(EXP_BIAS_SHIFT) - f.exp;
        shifted = sig >> sh;
        fixed   = '0;
        err     = 1'b0;
        if (f.exp == 8'hFF) begin
            err = 1'b1;
        end else if (f.sign && (f.exp != 8'd0 || f.man != 23'd0)) begin
            err = 1'b1;
        end else if (f.exp == 8'd0) begin
            fixed = '0;
        end else if (f.exp >= 8'(EXP_ERR_MIN)) begin
            err = 1'b1;
        end else if (f.exp > 8'(EXP_ZERO_MAX)) begin
            if (shifted >= 24'(FULL_SCALE)) begin
                err = 1'b1;
            end else begin
                fixed = shifted[FIX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/angle_to_arinc.sv
// Float degrees to 12-bit ARINC binary angle via unpack, round and a bit-serial SAR.
// Fixed 14-cycle latency; one job in flight, outputs held until out_ready.
module angle_to_arinc
    import arinc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_angle,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_err
);

    enc_state_t        state_q, state_d;
    logic [31:0]       angle_q;
    logic [FIX_W-1:0]  fixed_c, fixed_q, rem_q;
    logic              err_c, err_q;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [FIX_W-1:0]  w_k, rnd;
    logic              take;

    fp32_to_fixdeg u_unpack (
        .angle (angle_q),
        .fixed (fixed_c),
        .err   (err_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = UNPACK;
            UNPACK:  state_d = ROUND;
            ROUND:   state_d = CONVERT;
            CONVERT: if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == IDLE);

    // Adding half an LSB makes the truncating SAR round to nearest; 360 wraps to 0.
    assign rnd    = fixed_q + HALF_LSB;
    assign w_k    = arinc_weight(cnt_q);
    assign take   = (rem_q >= w_k);
    assign code_d = code_q | (take ? (CODE_W'(1) << cnt_q) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            angle_q   <= '0;
            fixed_q   <= '0;
            err_q     <= 1'b0;
            rem_q     <= '0;
            code_q    <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) angle_q <= in_angle;
                end
                UNPACK: begin
                    fixed_q <= fixed_c;
                    err_q   <= err_c;
                end
                ROUND: begin
                    rem_q  <= (rnd >= FULL_SCALE) ? (rnd - FULL_SCALE) : rnd;
                    code_q <= '0;
                    cnt_q  <= CNT_W'(CODE_W - 1);
                end
                CONVERT: begin
                    if (take) rem_q <= rem_q - w_k;
                    code_q <= code_d;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        out_valid <= 1'b1;
                        out_code  <= err_q ? '0 : code_d;
                        out_err   <= err_q;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_angle_to_arinc.sv
// Directed-vector bench for angle_to_arinc: codes, errors, latency, backpressure, reset abort.
module tb_angle_to_arinc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_angle;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_code;
    logic        out_err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    angle_to_arinc dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts edges after the accept edge until out_valid rises (bounded).
    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_job(input string tag, input logic [31:0] a,
                           input logic [11:0] exp_code, input logic exp_err);
        int n;
        @(negedge clk);
        check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_angle = a;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(n);
        check_eq({tag, " latency"}, 32'(n), 32'd14);
        check_eq({tag, " code"}, 32'(out_code), 32'(exp_code));
        check_eq({tag, " err"}, 32'(out_err), 32'(exp_err));
        @(posedge clk);
        #1;
        check_eq({tag, " valid drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, " idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_angle  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset in_ready", 32'(in_ready), 32'd1);
        check_eq("reset out_valid", 32'(out_valid), 32'd0);
        check_eq("reset out_code", 32'(out_code), 32'd0);
        check_eq("reset out_err", 32'(out_err), 32'd0);
        rst = 1'b0;

        run_job("deg90",    32'h42B40000, 12'h400, 1'b0);
        run_job("deg45",    32'h42340000, 12'h200, 1'b0);
        run_job("deg180",   32'h43340000, 12'h800, 1'b0);
        run_job("deg270",   32'h43870000, 12'hC00, 1'b0);
        run_job("deg1",     32'h3F800000, 12'h00B, 1'b0);
        run_job("pzero",    32'h00000000, 12'h000, 1'b0);
        run_job("nzero",    32'h80000000, 12'h000, 1'b0);
        run_job("denorm",   32'h00000001, 12'h000, 1'b0);
        run_job("halflsb",  32'h3D340000, 12'h001, 1'b0);
        run_job("wrap",     32'h43B3FEB8, 12'h000, 1'b0);
        run_job("neg1",     32'hBF800000, 12'h000, 1'b1);
        run_job("nan",      32'h7FC00000, 12'h000, 1'b1);
        run_job("deg360",   32'h43B40000, 12'h000, 1'b1);
        run_job("big",      32'h49742400, 12'h000, 1'b1);

        // Backpressure: result held, second request blocked until taken.
        out_ready = 1'b0;
        @(negedge clk);
        in_angle = 32'h42B40000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_angle = 32'h42340000;
        wait_result(n);
        check_eq("bp latency", 32'(n), 32'd14);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp hold valid", 32'(out_valid), 32'd1);
            check_eq("bp hold code", 32'(out_code), 32'h400);
            check_eq("bp no accept", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp release idle", 32'(in_ready), 32'd1);
        check_eq("bp release valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(n);
        check_eq("bp next latency", 32'(n), 32'd14);
        check_eq("bp next code", 32'(out_code), 32'h200);
        @(posedge clk);
        #1;

        // Reset during the sixth CONVERT cycle.
        @(negedge clk);
        in_angle = 32'h42B40000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("abort valid", 32'(out_valid), 32'd0);
        check_eq("abort in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_eq("abort no result", 32'(seen), 32'd0);
        run_job("post reset 90", 32'h42B40000, 12'h400, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
